// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker
//
// Read-side consumer for the async FIFO. Pulls one DW-bit word from a show-ahead
// FIFO, holds it, and emits it as DW/OW slices on a valid/ready stream,
// least-significant slice first. The next word is fetched on the same edge that
// takes the last slice of the current one, so back-to-back words have no bubble.
//
// Ports:
//   clk           read-domain clock (FIFO read clock)
//   reset         synchronous, active-high reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO read strobe (combinational)
//   fifo_rd_data  FIFO head word (show-ahead)
//   out_valid     slice valid
//   out_ready     downstream accept
//   out_data      current slice
//   out_last      current slice is the last slice of its word
//   word_cnt      count of fully consumed words, modulo 2^CW
//
// fifo_rd_en depends combinationally on out_ready; the downstream must not
// derive out_ready combinationally from fifo_rd_en.

module fifo_word_unpacker #(
    parameter int unsigned DW = 32,
    parameter int unsigned OW = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic [CW-1:0] word_cnt
);

    // DW/OW must be a power of two >= 2, so IdxW >= 1.
    localparam int unsigned Ratio = DW / OW;
    localparam int unsigned IdxW = $clog2(Ratio);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

    typedef enum logic [0:0] {
        StEmpty,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   word_q;
    logic [IdxW-1:0] idx_q;
    logic [CW-1:0]   word_cnt_q;
    logic            take;

    assign out_valid = (state_q == StHold);
    assign out_data  = word_q[idx_q*OW +: OW];
    assign out_last  = out_valid && (idx_q == LastIdx);
    assign take      = out_valid && out_ready;
    assign word_cnt  = word_cnt_q;

    // Read when nothing is held, or when the last slice leaves this cycle.
    // Gated by reset so the FIFO pointer never moves while we are being cleared.
    assign fifo_rd_en = !reset && !fifo_empty && ((state_q == StEmpty) || (take && out_last));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (fifo_rd_en) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (take && out_last) begin
                    state_d = fifo_rd_en ? StHold : StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            word_q     <= '0;
            idx_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_rd_en) begin
                word_q <= fifo_rd_data;
                idx_q  <= '0;
            end else if (take) begin
                idx_q <= idx_q + 1'b1;
            end
            if (take && out_last) begin
                word_cnt_q <= word_cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker (DW=32, OW=8, CW=16) with a small
// show-ahead FIFO model held in a queue.

module tb_fifo_word_unpacker;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] word_cnt;

    int total = 0;
    int bad = 0;

    logic [31:0] fq[$];
    logic [7:0]  bp_data [7];

    fifo_word_unpacker #(
        .DW(32),
        .OW(8),
        .CW(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .word_cnt    (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present the queue head as the FIFO's show-ahead port.
    task automatic fifo_drive();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    // Set inputs for this cycle and let combinational outputs settle.
    task automatic setup(input logic rdy);
        out_ready = rdy;
        fifo_drive();
        #1;
    endtask

    // Advance one clock; pop the FIFO model if a read was strobed.
    task automatic tick();
        logic re;
        re = fifo_rd_en;
        @(posedge clk);
        if (re && fq.size() != 0) fq.delete(0);
        #1;
        fifo_drive();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fq.delete();
        fq.push_back(32'h12345678);
        for (int i = 0; i < 3; i++) begin
            setup(1'b1);
            total++;
            if (fifo_rd_en !== 1'b0) begin
                bad++; $display("FAIL reset_rd_en cyc%0d: got %b want 0", i, fifo_rd_en);
            end
            tick();
        end
        fq.delete();
        reset = 1'b0;
        setup(1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++;
        if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
        total++;
        if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", out_last); end
        total++;
        if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_idle_rd: got %b want 0", fifo_rd_en); end
        tick();
    endtask

    task automatic test_single();
        logic [7:0] exp_d;
        fq.push_back(32'hDDCCBBAA);
        setup(1'b1);
        total++;
        if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL single_rd: got %b want 1", fifo_rd_en); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid: got %b want 0", out_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'hAA + 8'(i * 17);
            setup(1'b1);
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid%0d: got %b want 1", i, out_valid); end
            total++;
            if (out_data !== exp_d) begin bad++; $display("FAIL single_data%0d: got %h want %h", i, out_data, exp_d); end
            total++;
            if (out_last !== (i == 3)) begin bad++; $display("FAIL single_last%0d: got %b want %b", i, out_last, i == 3); end
            total++;
            if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL single_extra_rd%0d: got %b want 0", i, fifo_rd_en); end
            tick();
        end
        setup(1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_post_valid: got %b want 0", out_valid); end
        total++;
        if (word_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", word_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        fq.push_back(32'h03020100);
        fq.push_back(32'h07060504);
        setup(1'b1);
        total++;
        if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL b2b_rd0: got %b want 1", fifo_rd_en); end
        tick();
        for (int i = 0; i < 8; i++) begin
            setup(1'b1);
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d: got %b want 1", i, out_valid); end
            total++;
            if (out_data !== 8'(i)) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, out_data, 8'(i)); end
            total++;
            if (out_last !== (i % 4 == 3)) begin bad++; $display("FAIL b2b_last%0d: got %b want %b", i, out_last, i % 4 == 3); end
            total++;
            if (fifo_rd_en !== (i == 3)) begin bad++; $display("FAIL b2b_rd%0d: got %b want %b", i, fifo_rd_en, i == 3); end
            tick();
        end
        setup(1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_post_valid: got %b want 0", out_valid); end
        total++;
        if (word_cnt !== 16'd3) begin bad++; $display("FAIL b2b_cnt: got %0d want 3", word_cnt); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [6:0] rdy_pat;
        logic [6:0] last_pat;
        rdy_pat  = 7'b1011001;   // 1,0,0,1,1,0,1 from bit 0
        last_pat = 7'b1100000;
        bp_data[0] = 8'h11; bp_data[1] = 8'h22; bp_data[2] = 8'h22; bp_data[3] = 8'h22;
        bp_data[4] = 8'h33; bp_data[5] = 8'h44; bp_data[6] = 8'h44;
        fq.push_back(32'h44332211);
        setup(1'b0);
        total++;
        if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL bp_rd0: got %b want 1", fifo_rd_en); end
        tick();
        for (int i = 0; i < 7; i++) begin
            setup(rdy_pat[i]);
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", i, out_valid); end
            total++;
            if (out_data !== bp_data[i]) begin bad++; $display("FAIL bp_data%0d: got %h want %h", i, out_data, bp_data[i]); end
            total++;
            if (out_last !== last_pat[i]) begin bad++; $display("FAIL bp_last%0d: got %b want %b", i, out_last, last_pat[i]); end
            total++;
            if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL bp_extra_rd%0d: got %b want 0", i, fifo_rd_en); end
            tick();
        end
        setup(1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_post_valid: got %b want 0", out_valid); end
        total++;
        if (word_cnt !== 16'd4) begin bad++; $display("FAIL bp_cnt: got %0d want 4", word_cnt); end
        tick();
    endtask

    task automatic test_empty_boundary();
        logic [7:0] exp_d;
        fq.push_back(32'h88776655);
        setup(1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'h55 + 8'(i * 17);
            setup(1'b1);
            total++;
            if (out_data !== exp_d) begin bad++; $display("FAIL eb_data%0d: got %h want %h", i, out_data, exp_d); end
            total++;
            if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL eb_rd%0d: got %b want 0", i, fifo_rd_en); end
            tick();
        end
        // Two idle cycles with the FIFO empty, then the load cycle.
        for (int i = 0; i < 3; i++) begin
            if (i == 2) fq.push_back(32'hA5A5A5A5);
            setup(1'b1);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL eb_gap_valid%0d: got %b want 0", i, out_valid); end
            total++;
            if (fifo_rd_en !== (i == 2)) begin bad++; $display("FAIL eb_gap_rd%0d: got %b want %b", i, fifo_rd_en, i == 2); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            setup(1'b1);
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL eb_new_valid%0d: got %b want 1", i, out_valid); end
            total++;
            if (out_data !== 8'hA5) begin bad++; $display("FAIL eb_new_data%0d: got %h want a5", i, out_data); end
            total++;
            if (out_last !== (i == 3)) begin bad++; $display("FAIL eb_new_last%0d: got %b want %b", i, out_last, i == 3); end
            tick();
        end
        setup(1'b1);
        total++;
        if (word_cnt !== 16'd6) begin bad++; $display("FAIL eb_cnt: got %0d want 6", word_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_word();
        fq.push_back(32'hDDCCBBAA);
        setup(1'b1);
        tick();
        setup(1'b1);
        total++;
        if (out_data !== 8'hAA) begin bad++; $display("FAIL rm_data0: got %h want aa", out_data); end
        tick();
        setup(1'b1);
        total++;
        if (out_data !== 8'hBB) begin bad++; $display("FAIL rm_data1: got %h want bb", out_data); end
        tick();
        reset = 1'b1;
        fq.push_back(32'h0F0E0D0C);
        setup(1'b1);
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rm_rd_in_reset: got %b want 0", fifo_rd_en); end
        tick();
        reset = 1'b0;
        setup(1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", out_valid); end
        total++;
        if (word_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt_clr: got %0d want 0", word_cnt); end
        total++;
        if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL rm_rd: got %b want 1", fifo_rd_en); end
        tick();
        for (int i = 0; i < 4; i++) begin
            setup(1'b1);
            total++;
            if (out_data !== 8'h0C + 8'(i)) begin bad++; $display("FAIL rm_new_data%0d: got %h want %h", i, out_data, 8'h0C + 8'(i)); end
            total++;
            if (out_last !== (i == 3)) begin bad++; $display("FAIL rm_new_last%0d: got %b want %b", i, out_last, i == 3); end
            tick();
        end
        setup(1'b1);
        total++;
        if (word_cnt !== 16'd1) begin bad++; $display("FAIL rm_cnt: got %0d want 1", word_cnt); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_post_valid: got %b want 0", out_valid); end
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        out_ready    = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = 32'h0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty_boundary();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
